// File: rtl/ppu_issue_adapter.sv
`default_nettype none
// ============================================================================
// Module  : ppu_issue_adapter
// Brief   : Feeds ppu_top from a ready/valid request FIFO and collects its
//           results into a ready/valid result FIFO. A credit counter keeps
//           every in-flight result room in the result FIFO.
//           Optional macro PPU_ISSUE_STATS_EN adds issued/completed counters.
// Rev     : 1.0  initial release
// ============================================================================
module ppu_issue_adapter #(
    parameter int WORD      = 32,
    parameter int OP_SIZE   = 3,
    parameter int REQ_DEPTH = 4,
    parameter int RES_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [WORD-1:0]              req_in1,
    input  logic [WORD-1:0]              req_in2,
    input  logic [OP_SIZE-1:0]           req_op,
    output logic                         ppu_valid_in,
    output logic [WORD-1:0]              ppu_in1,
    output logic [WORD-1:0]              ppu_in2,
    output logic [OP_SIZE-1:0]           ppu_op,
    input  logic [WORD-1:0]              ppu_out,
    input  logic                         ppu_valid_o,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WORD-1:0]              res_data,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [$clog2(RES_DEPTH):0]   in_flight,
`ifdef PPU_ISSUE_STATS_EN
    output logic [31:0]                  issued_cnt,
    output logic [31:0]                  completed_cnt,
`endif
    output logic                         err_spurious
);

    localparam int c_RA = $clog2(REQ_DEPTH);
    localparam int c_SA = $clog2(RES_DEPTH);
    localparam int c_CW = c_SA + 1;
    localparam logic [c_RA:0]   c_REQ_FULL  = (c_RA+1)'(REQ_DEPTH);
    localparam logic [c_CW-1:0] c_RES_FULL  = c_CW'(RES_DEPTH);
    localparam logic [c_CW:0]   c_RES_LIMIT = (c_CW+1)'(RES_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WORD-1:0]    r_req_in1 [REQ_DEPTH];
    logic [WORD-1:0]    r_req_in2 [REQ_DEPTH];
    logic [OP_SIZE-1:0] r_req_op  [REQ_DEPTH];
    logic [c_RA-1:0]    r_req_wr;
    logic [c_RA-1:0]    r_req_rd;
    logic [c_RA:0]      r_req_cnt;

    logic [WORD-1:0]    r_res_mem [RES_DEPTH];
    logic [c_SA-1:0]    r_res_wr;
    logic [c_SA-1:0]    r_res_rd;
    logic [c_CW-1:0]    r_res_cnt;

    logic               w_req_push;
    logic               w_issue;
    logic               w_clear;
    logic               w_ret;
    logic               w_res_push;
    logic               w_res_pop;
    logic               w_spur;
    logic [c_CW:0]      w_occupied;

    assign w_clear    = (r_state == CLEAR);
    assign req_ready  = !rst && (r_state == RUN) && (r_req_cnt != c_REQ_FULL);
    assign w_req_push = req_valid && req_ready;

    // Every result slot is either occupied or promised to an in-flight op.
    assign w_occupied = {1'b0, r_res_cnt} + {1'b0, in_flight};
    assign w_issue    = (r_state == RUN) && (r_req_cnt != '0) && (w_occupied < c_RES_LIMIT);

    assign res_valid  = (r_res_cnt != '0);
    assign res_data   = res_valid ? r_res_mem[r_res_rd] : '0;
    assign w_res_pop  = res_valid && res_ready;
    assign w_ret      = ppu_valid_o && (in_flight != '0);
    assign w_res_push = w_ret && ((r_res_cnt != c_RES_FULL) || w_res_pop);
    assign w_spur     = ppu_valid_o && !w_res_push;
    assign flush_done = w_clear;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (flush) w_state_nxt = DRAIN;
            DRAIN:   if (in_flight == '0) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // Storage arrays carry no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (w_req_push) begin
            r_req_in1[r_req_wr] <= req_in1;
            r_req_in2[r_req_wr] <= req_in2;
            r_req_op[r_req_wr]  <= req_op;
        end
        if (w_res_push) r_res_mem[r_res_wr] <= ppu_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_wr  <= '0;
            r_req_rd  <= '0;
            r_req_cnt <= '0;
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
        end else if (w_clear) begin
            r_req_wr  <= '0;
            r_req_rd  <= '0;
            r_req_cnt <= '0;
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_req_push) r_req_wr <= r_req_wr + 1'b1;
            if (w_issue)    r_req_rd <= r_req_rd + 1'b1;
            case ({w_req_push, w_issue})
                2'b10:   r_req_cnt <= r_req_cnt + 1'b1;
                2'b01:   r_req_cnt <= r_req_cnt - 1'b1;
                default: r_req_cnt <= r_req_cnt;
            endcase
            if (w_res_push) r_res_wr <= r_res_wr + 1'b1;
            if (w_res_pop)  r_res_rd <= r_res_rd + 1'b1;
            case ({w_res_push, w_res_pop})
                2'b10:   r_res_cnt <= r_res_cnt + 1'b1;
                2'b01:   r_res_cnt <= r_res_cnt - 1'b1;
                default: r_res_cnt <= r_res_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ppu_valid_in <= 1'b0;
            ppu_in1      <= '0;
            ppu_in2      <= '0;
            ppu_op       <= '0;
            in_flight    <= '0;
            err_spurious <= 1'b0;
        end else begin
            ppu_valid_in <= w_issue;
            if (w_issue) begin
                ppu_in1 <= r_req_in1[r_req_rd];
                ppu_in2 <= r_req_in2[r_req_rd];
                ppu_op  <= r_req_op[r_req_rd];
            end
            case ({w_issue, w_ret})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
            if (w_clear)     err_spurious <= 1'b0;
            else if (w_spur) err_spurious <= 1'b1;
        end
    end

`ifdef PPU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_cnt    <= '0;
            completed_cnt <= '0;
        end else begin
            if (w_issue)    issued_cnt    <= issued_cnt + 32'd1;
            if (w_res_push) completed_cnt <= completed_cnt + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
